// File: rtl/ll_sum_datapath.sv
// ll_sum_datapath
// Datapath for the linked-list-sum controller. It holds the node memory, the
// SUM accumulator and the NEXT pointer register. The controller drives the
// load enables and selects, and branches on next_zero.
//
// Node layout: mem[p] is the pointer to the next node (low AW bits used), and
// mem[p+1] is the node value. Pointer 0 terminates the list.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   head               address of the first node (0 = empty list)
//   LD_SUM, SUM_SEL    SUM load enable; source 0 -> zero, 1 -> SUM + mem_rd
//   LD_NEXT, NEXT_SEL  NEXT load enable; source 0 -> head, 1 -> mem_rd[AW-1:0]
//   A_SEL              read address 0 -> NEXT, 1 -> NEXT+1 (wraps mod 2**AW)
//   wr_en/addr/data    host preload port (synchronous write)
//   next_zero          NEXT == 0
//   sum_out, next_out  current SUM and NEXT registers
//   sum_ovf            sticky carry-out flag
//
// Optional feature macro: LL_SUM_OVF_EN. When defined, sum_ovf latches any
// carry out of an accumulate. It is cleared by rst or by a zeroing SUM load.
// When undefined, sum_ovf is tied low.
module ll_sum_datapath #(
  parameter int N  = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] head,
  input  logic          LD_SUM,
  input  logic          LD_NEXT,
  input  logic          A_SEL,
  input  logic          SUM_SEL,
  input  logic          NEXT_SEL,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  output logic          next_zero,
  output logic [N-1:0]  sum_out,
  output logic [AW-1:0] next_out,
  output logic          sum_ovf
);

  localparam int DEPTH = 2 ** AW;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] addr_s;
  logic [N-1:0]  mem_rd_s;
  logic [N-1:0]  sum_q, sum_d;
  logic [AW-1:0] next_q, next_d;
  logic [N-1:0]  sum_add_s;

  // Read address: NEXT+1 wraps naturally in AW bits.
  always_comb begin
    addr_s = next_q;
    if (A_SEL) begin
      addr_s = next_q + AW'(1);
    end else begin
      addr_s = next_q;
    end
  end

  // Asynchronous read. A same-cycle write is not visible until the next cycle.
  assign mem_rd_s = mem_q[addr_s];

`ifdef LL_SUM_OVF_EN
  logic [N:0] sum_ext_s;
  logic       ovf_q, ovf_d;

  assign sum_ext_s = {1'b0, sum_q} + {1'b0, mem_rd_s};
  assign sum_add_s = sum_ext_s[N-1:0];

  // The overflow flag is sticky across accumulates and cleared by a zeroing load.
  always_comb begin
    ovf_d = ovf_q;
    if (LD_SUM) begin
      if (SUM_SEL) begin
        ovf_d = ovf_q | sum_ext_s[N];
      end else begin
        ovf_d = 1'b0;
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign sum_ovf = ovf_q;
`else
  assign sum_add_s = sum_q + mem_rd_s;
  assign sum_ovf   = 1'b0;
`endif

  // Next-state for SUM and NEXT. Both may load from the same mem_rd.
  always_comb begin
    sum_d  = sum_q;
    next_d = next_q;
    if (LD_SUM) begin
      if (SUM_SEL) begin
        sum_d = sum_add_s;
      end else begin
        sum_d = {N{1'b0}};
      end
    end else begin
      sum_d = sum_q;
    end
    if (LD_NEXT) begin
      if (NEXT_SEL) begin
        next_d = mem_rd_s[AW-1:0];
      end else begin
        next_d = head;
      end
    end else begin
      next_d = next_q;
    end
  end

  // Datapath registers. rst overrides any load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= {N{1'b0}};
      next_q <= {AW{1'b0}};
    end else begin
      sum_q  <= sum_d;
      next_q <= next_d;
    end
  end

  // Host preload port. It is honoured even while rst is asserted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign next_zero = (next_q == {AW{1'b0}});
  assign sum_out   = sum_q;
  assign next_out  = next_q;

endmodule

// File: tb/tb_ll_sum_datapath.sv
// Directed testbench for ll_sum_datapath (N=32, AW=8). The expected values
// are hand-computed from the node layout written into memory.
module tb_ll_sum_datapath;

  localparam int N  = 32;
  localparam int AW = 8;

`ifdef LL_SUM_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] head;
  logic          LD_SUM, LD_NEXT, A_SEL, SUM_SEL, NEXT_SEL;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          next_zero;
  logic [N-1:0]  sum_out;
  logic [AW-1:0] next_out;
  logic          sum_ovf;

  int vec_cnt = 0;
  int err_cnt = 0;

  ll_sum_datapath #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .head(head),
    .LD_SUM(LD_SUM), .LD_NEXT(LD_NEXT), .A_SEL(A_SEL),
    .SUM_SEL(SUM_SEL), .NEXT_SEL(NEXT_SEL),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .next_zero(next_zero), .sum_out(sum_out), .next_out(next_out),
    .sum_ovf(sum_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controls. The wr_* signals are used as pre-set by the
  // caller. Everything is deasserted afterwards. Outputs are sampled 1 ns after the edge.
  task automatic step(input logic ls, input logic ln, input logic as,
                      input logic ss, input logic ns);
    LD_SUM = ls; LD_NEXT = ln; A_SEL = as; SUM_SEL = ss; NEXT_SEL = ns;
    @(posedge clk); #1;
    LD_SUM = 1'b0; LD_NEXT = 1'b0; A_SEL = 1'b0; SUM_SEL = 1'b0; NEXT_SEL = 1'b0;
    wr_en = 1'b0; rst = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [N-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; head = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    LD_SUM = 1'b0; LD_NEXT = 1'b0; A_SEL = 1'b0; SUM_SEL = 1'b0; NEXT_SEL = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    wr(8'd4, 32'd10); wr(8'd5, 32'd7); wr(8'd10, 32'd0); wr(8'd11, 32'd5);
    wr(8'd6, 32'd3);  wr(8'd1, 32'd2); wr(8'd255, 32'd0); wr(8'd0, 32'hFFFF_FFFF);

    // Load activity, then reset during a SUM load.
    head = 8'd4;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_sum", sum_out, 64'd7);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_sum", sum_out, 64'd0);
    chk("rst_next", next_out, 64'd0);
    chk("rst_nz", next_zero, 64'd1);
    chk("rst_ovf", sum_ovf, 64'd0);

    // Two-node list: 7 + 5 = 12. This also confirms that reset left memory intact.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("init_next", next_out, 64'd4);
    chk("init_nz", next_zero, 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("n1_sum", sum_out, 64'd7);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("n1_next", next_out, 64'd10);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("list_sum", sum_out, 64'd12);
    chk("list_next", next_out, 64'd0);
    chk("list_nz", next_zero, 64'd1);

    // Empty list.
    head = 8'd0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("empty_nz", next_zero, 64'd1);
    chk("empty_sum", sum_out, 64'd0);

    // Wrap/overflow: preload SUM=2 from mem[1], set NEXT=255, then read mem[0].
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_sum", sum_out, 64'd2);
    head = 8'd255;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_next", next_out, 64'd255);
    chk("pre_ovf", sum_ovf, 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("wrap_sum", sum_out, 64'd1);
    chk("wrap_ovf", sum_ovf, {63'd0, EXP_OVF});
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("wrap_sum2", sum_out, 64'd0);
    chk("ovf_sticky", sum_ovf, {63'd0, EXP_OVF});
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_clr", sum_ovf, 64'd0);

    // NEXT ignores the upper mem_rd bits.
    wr(8'd255, 32'hABCD_0007);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("next_trunc", next_out, 64'd7);

    // Write/read collision at mem[6] (old value 3, new value 9).
    head = 8'd5;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wr_en = 1'b1; wr_addr = 8'd6; wr_data = 32'd9;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("coll_old", sum_out, 64'd3);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("coll_new", sum_out, 64'd12);

    // Simultaneous loads from mem[5]=7: SUM=19, NEXT=7.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("both_sum", sum_out, 64'd19);
    chk("both_next", next_out, 64'd7);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("hold_sum", sum_out, 64'd19);
    chk("hold_next", next_out, 64'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ll_sum_datapath.md
Name: ll_sum_datapath

Overview:
- Datapath that answers the linked-list-sum control FSM. It consumes LD_SUM, LD_NEXT, A_SEL, SUM_SEL and NEXT_SEL, and returns next_zero.
- Holds the node memory, the SUM accumulator and the NEXT pointer register.
- A host write port preloads the list before start. The total is read from sum_out once the FSM raises DONE.

Parameters:
- N, 32, data/accumulator width in bits.
- AW, 8, memory address width; depth = 2**AW words.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- head  input  AW  address of first list node; 0 = empty list
- LD_SUM  input  1  load enable for SUM register
- LD_NEXT  input  1  load enable for NEXT register
- A_SEL  input  1  memory address select: 0 -> NEXT, 1 -> NEXT+1
- SUM_SEL  input  1  SUM source: 0 -> zero, 1 -> SUM + mem_rd
- NEXT_SEL  input  1  NEXT source: 0 -> head, 1 -> mem_rd[AW-1:0]
- wr_en  input  1  host memory write strobe
- wr_addr  input  AW  host write address
- wr_data  input  N  host write data
- next_zero  output  1  high when NEXT == 0
- sum_out  output  N  current SUM register
- next_out  output  AW  current NEXT register (debug)
- sum_ovf  output  1  sticky accumulator overflow (see Optional Feature)

Behaviour:
- Node layout: mem[p] = pointer to next node (low AW bits used); mem[p+1] = node value. Pointer 0 terminates the list, so address 0 never holds a node.
- Reset: on a clk edge with rst=1, SUM=0, NEXT=0, sum_ovf=0. Memory contents are not cleared.
  - Consequence: next_zero=1 after reset.
  - rst has priority over LD_*, including when reset arrives mid-traversal. The host write port is still honoured during rst.
- Read address:
  - A_SEL=0: addr = NEXT.
  - A_SEL=1: addr = NEXT+1 mod 2**AW. NEXT = 2**AW-1 wraps to address 0.
- Memory read is asynchronous (combinational): mem_rd = mem[addr].
- Memory write is synchronous: on a clk edge with wr_en=1, mem[wr_addr] <= wr_data.
  - A same-cycle read of wr_addr returns the old contents. The new value is visible the next cycle.
- SUM register: updates on a clk edge when LD_SUM=1.
  - SUM_SEL=0: SUM <= 0.
  - SUM_SEL=1: SUM <= (SUM + mem_rd) mod 2**N, unsigned wrap.
  - LD_SUM=0: SUM holds.
- NEXT register: updates on a clk edge when LD_NEXT=1.
  - NEXT_SEL=0: NEXT <= head.
  - NEXT_SEL=1: NEXT <= mem_rd[AW-1:0]; upper mem_rd bits are ignored.
  - LD_NEXT=0: NEXT holds.
- LD_SUM and LD_NEXT asserted together: both registers update from the same mem_rd. The FSM never does this, but the datapath is defined for it.
- Latency: next_zero, sum_out and next_out are combinational from registers, so they are valid in the cycle after the load edge. next_zero has no extra pipeline stage, so the FSM's NEXT-state decision sees the pointer loaded in the preceding cycle.
- Self-loop lists (pointer to own node) never terminate; bounding that is the controller's responsibility.
- Empty list (head=0): after NEXT <= head, next_zero=1 immediately.

Optional Feature:
- Macro: LL_SUM_OVF_EN
- Defined: sum_ovf is set when a SUM_SEL=1 load produces a carry out of bit N-1. It is sticky until rst or a SUM_SEL=0 load clears it; it is not cleared on wrap-back.
- Undefined: sum_ovf is tied to 0 and no carry logic is synthesised.

Test Plan:
- Reset check: rst=1 for 1 cycle after arbitrary LD activity -> sum_out=0, next_out=0, next_zero=1, sum_ovf=0.
- Two-node list:
  - Setup: write mem[4]=10, mem[5]=7, mem[10]=0, mem[11]=5; head=4. Init pulse LD_SUM=1,SUM_SEL=0 with LD_NEXT=1,NEXT_SEL=0.
  - Pulse sequence:
    - SUM (LD_SUM=1, A_SEL=1, SUM_SEL=1)
    - NEXT (LD_NEXT=1, A_SEL=0, NEXT_SEL=1)
    - SUM
    - NEXT
  - Required response: sum_out=12, next_out=0, next_zero=1.
- Wrap/overflow:
  - Setup: N=32, AW=8; mem[255]=0, mem[0]=0xFFFFFFFF; SUM preloaded to 2; NEXT=255.
  - Pulse: SUM with A_SEL=1 (address wraps to 0).
  - Required response: sum_out=1. With LL_SUM_OVF_EN, sum_ovf=1 and it stays 1 after further SUM loads.
- Write/read collision: wr_en to mem[6]=9 in the same cycle as a SUM load at NEXT+1=6 (old mem[6]=3) -> SUM increases by 3; the next SUM load increases it by 9.
- Empty list: head=0, NEXT init load -> next_zero=1 the following cycle; sum_out stays 0.
- Reset mid-operation: assert rst during a SUM load after sum_out=7 -> sum_out=0, NEXT=0 next cycle; memory still reads back its prior contents.
